keypad_scan: RTL and testbench

- 4x4 matrix keypad scanner and encoder. It is the input-side counterpart of the display scan counter: instead of cycling digit selects outward, it cycles row drives outward and reads column returns inward.
- Drives one row low at a time and samples the active-low columns.
- Debounces a single pressed key, then emits a 4-bit hex key code with a one-cycle valid strobe and a held level.
- Sits between the keypad pins and the display mux/decoder logic.

---
 rtl/keypad_scan.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scan.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives rows low one at a time, debounces a single
// pressed key and reports its hex code with a one-cycle strobe and a held level.
module keypad_scan #(
  parameter int SCAN_DIV    = 1000,
  parameter int DEB_SAMPLES = 4
) (
  input  logic       ck,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  // state    | meaning
  // SCAN     | stepping rows, waiting for a single pressed column
  // DEBOUNCE | row held, counting consecutive samples of the same column
  // HELD     | key accepted, counting idle samples before releasing
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SAMPLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_SAMPLES);

  state_t state, state_nxt;

  logic [3:0]    col_m, col_s;
  logic [DW-1:0] div;
  logic [1:0]    r, r_nxt;
  logic [1:0]    cand_c, cand_nxt;
  logic [1:0]    col_idx;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [CW-1:0] rel_cnt, rel_nxt;
  logic [3:0]    row_nxt;
  logic [3:0]    code;
  logic          sample_tick;
  logic          is_idle, is_single;
  logic          accept, advance;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    case ({row, col})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'hE;
      4'hD: k = 4'h0;
      4'hE: k = 4'hF;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  // Columns are asynchronous to ck; two flops before anything looks at them.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      col_m <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst)                 div <= '0;
    else if (div == DIV_LAST) div <= '0;
    else                     div <= div + DW'(1);
  end

  assign sample_tick = (div == DIV_LAST);
  assign is_idle     = (col_s == 4'b1111);
  assign is_single   = $onehot(~col_s);

  always_comb begin
    col_idx = 2'd0;
    case (col_s)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // State register
  always_ff @(posedge ck or posedge rst) begin
    if (rst) state <= SCAN;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    if (sample_tick) begin
      case (state)
        SCAN: begin
          if (is_single) begin
            if (DEB_SAMPLES == 1) accept    = 1'b1;
            else                  state_nxt = DEBOUNCE;
          end else begin
            advance = 1'b1;
          end
        end
        DEBOUNCE: begin
          if (is_single && (col_idx == cand_c)) begin
            if ((deb_cnt + CW'(1)) == DEB_LAST) accept = 1'b1;
          end else begin
            state_nxt = SCAN;
            advance   = 1'b1;
          end
        end
        HELD: begin
          if (is_idle && ((rel_cnt + CW'(1)) == DEB_LAST)) begin
            state_nxt = SCAN;
            advance   = 1'b1;
          end
        end
        default: begin
          state_nxt = SCAN;
          advance   = 1'b1;
        end
      endcase
    end
    if (accept) state_nxt = HELD;
  end

  // Output and datapath next values
  always_comb begin
    r_nxt    = advance ? (r + 2'd1) : r;
    cand_nxt = cand_c;
    deb_nxt  = deb_cnt;
    rel_nxt  = rel_cnt;
    if (sample_tick) begin
      case (state)
        SCAN: begin
          if (is_single) begin
            cand_nxt = col_idx;
            deb_nxt  = CW'(1);
          end
        end
        DEBOUNCE: begin
          if (is_single && (col_idx == cand_c)) deb_nxt = deb_cnt + CW'(1);
        end
        HELD: begin
          if (is_idle) rel_nxt = rel_cnt + CW'(1);
          else         rel_nxt = '0;
        end
        default: ;
      endcase
    end
    if (accept) rel_nxt = '0;
    row_nxt = ~(4'b0001 << r_nxt);
    code    = key_code(r, cand_nxt);
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r         <= 2'd0;
      row_n     <= 4'b1110;
      cand_c    <= 2'd0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      r         <= r_nxt;
      row_n     <= row_nxt;
      cand_c    <= cand_nxt;
      deb_cnt   <= deb_nxt;
      rel_cnt   <= rel_nxt;
      key_valid <= accept;
      key_held  <= (state_nxt == HELD);
      if (accept) key <= code;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: directed table, hand sequences for bounce and reset,
// and random key activity checked cycle by cycle against a keypad-level model.
module tb_keypad_scan;
  localparam int SD = 8;
  localparam int DS = 3;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;
  logic [15:0] pressed = '0;

  keypad_scan #(.SCAN_DIV(SD), .DEB_SAMPLES(DS)) dut (
    .ck(ck), .rst(rst), .col_n(col_n), .row_n(row_n),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 ck = ~ck;

  // Physical keypad: a pressed key shorts its column to a driven-low row.
  always_comb begin
    col_n = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++)
        if (!row_n[rr] && pressed[rr*4+cc]) col_n[cc] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  // Reference model: st 0=scanning, 1=confirming, 2=key held
  int m_r, m_div, m_st, m_deb, m_rel, m_cand;
  logic [3:0] m_key, m_s1, m_s2;
  logic m_valid, m_held;
  int lut[16];

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          cycles;
    logic [3:0]  exp_key;
    int          exp_strobes;
    logic        exp_held;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_cols(input int r);
    logic [3:0] v = 4'hF;
    for (int c = 0; c < 4; c++) if (pressed[r*4+c]) v[c] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_r = 0; m_div = 0; m_st = 0; m_deb = 0; m_rel = 0; m_cand = 0;
    m_key = 4'h0; m_s1 = 4'hF; m_s2 = 4'hF; m_valid = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_accept();
    m_key = lut[m_r*4 + m_cand][3:0];
    m_valid = 1'b1; m_held = 1'b1; m_rel = 0; m_st = 2;
  endtask

  task automatic tick();
    logic [3:0] cn, smp, er;
    int zeros, c;
    cn = model_cols(m_r);
    @(posedge ck);
    smp = m_s2; m_s2 = m_s1; m_s1 = cn; m_valid = 1'b0;
    if (m_div == SD - 1) begin
      zeros = 0; c = 0;
      for (int i = 0; i < 4; i++) if (!smp[i]) begin zeros++; c = i; end
      if (m_st == 0) begin
        if (zeros == 1) begin
          m_cand = c; m_deb = 1;
          if (m_deb >= DS) model_accept(); else m_st = 1;
        end else m_r = (m_r + 1) % 4;
      end else if (m_st == 1) begin
        if (zeros == 1 && c == m_cand) begin
          m_deb++;
          if (m_deb >= DS) model_accept();
        end else begin
          m_st = 0; m_r = (m_r + 1) % 4;
        end
      end else begin
        if (zeros == 0) begin
          m_rel++;
          if (m_rel >= DS) begin m_st = 0; m_held = 1'b0; m_r = (m_r + 1) % 4; end
        end else m_rel = 0;
      end
    end
    m_div = (m_div + 1) % SD;
    #1;
    if (key_valid) strobes++;
    er = ~(4'b0001 << m_r);
    check("row_n", row_n, er);
    check("key", key, m_key);
    check("key_valid", key_valid, m_valid);
    check("key_held", key_held, m_held);
  endtask

  task automatic wait_state(input string name, input int st, input int budget);
    int n = 0;
    while (m_st != st && n < budget) begin tick(); n++; end
    check(name, int'(n < budget), 1);
  endtask

  initial begin
    logic [3:0] rowseq[5];
    logic [15:0] ks;
    lut = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
    rowseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset and idle scan
    model_reset();
    repeat (3) @(posedge ck);
    #1;
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    rst = 1'b0;
    for (int i = 1; i < 5; i++) begin
      repeat (SD) tick();
      check("idle_row", row_n, rowseq[i]);
    end

    vecs.push_back('{"press_5",    16'h0020, 200, 4'h5, 1, 1'b1});
    vecs.push_back('{"release_5",  16'h0000,  64, 4'h5, 0, 1'b0});
    vecs.push_back('{"press_star", 16'h1000, 200, 4'hE, 1, 1'b1});
    vecs.push_back('{"release_st", 16'h0000,  64, 4'hE, 0, 1'b0});
    vecs.push_back('{"press_hash", 16'h4000, 200, 4'hF, 1, 1'b1});
    vecs.push_back('{"release_hs", 16'h0000,  64, 4'hF, 0, 1'b0});
    vecs.push_back('{"press_A",    16'h0008, 200, 4'hA, 1, 1'b1});
    vecs.push_back('{"release_A",  16'h0000,  64, 4'hA, 0, 1'b0});
    vecs.push_back('{"ghost_r0",   16'h0003, 100, 4'hA, 0, 1'b0});
    vecs.push_back('{"ghost_off",  16'h0000,  40, 4'hA, 0, 1'b0});

    for (int i = 0; i < 2; i++) begin
      pressed = vecs[i].keys; strobes = 0;
      repeat (vecs[i].cycles) tick();
      check({vecs[i].name, "_strobes"}, strobes, vecs[i].exp_strobes);
      check({vecs[i].name, "_key"}, key, vecs[i].exp_key);
      check({vecs[i].name, "_held"}, key_held, vecs[i].exp_held);
    end

    // Bounce: '9' released after the first qualifying sample
    pressed = 16'h0400;
    wait_state("wait_bounce_deb", 1, 100);
    pressed = '0; strobes = 0;
    repeat (SD) tick();
    check("bounce_row", row_n, 4'b0111);
    repeat (40) tick();
    check("bounce_strobes", strobes, 0);
    check("bounce_key", key, 4'h5);

    for (int i = 2; i < vecs.size(); i++) begin
      pressed = vecs[i].keys; strobes = 0;
      repeat (vecs[i].cycles) tick();
      check({vecs[i].name, "_strobes"}, strobes, vecs[i].exp_strobes);
      check({vecs[i].name, "_key"}, key, vecs[i].exp_key);
      check({vecs[i].name, "_held"}, key_held, vecs[i].exp_held);
    end

    // Random key activity, occasional second key
    for (int it = 0; it < 40; it++) begin
      ks = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) ks = ks | (16'h0001 << $urandom_range(0, 15));
      pressed = ks;
      repeat ($urandom_range(0, 90)) tick();
      pressed = '0;
      repeat ($urandom_range(0, 60)) tick();
    end
    pressed = '0;
    repeat (40) tick();

    // Reset while a key is held
    pressed = 16'h0020;
    wait_state("wait_held", 2, 200);
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_row", row_n, 4'b1110);
    check("async_rst_key", key, 4'h0);
    check("async_rst_held", key_held, 0);
    check("async_rst_valid", key_valid, 0);
    model_reset();
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;
    pressed = '0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
